// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit for the execute stage.
// A radix-2 shift-add multiplier and a radix-2 restoring divider share one
// 64-bit accumulator and produce one bit per RUN cycle. Each op takes 32 RUN
// cycles followed by a single FIN cycle.
// Configuration macro: MULDIV_DIV_EN. If it is defined, the divider is built.
// If it is not defined, DIV/DIVU/REM/REMU go straight to FIN and return zero.
`timescale 1ns/1ps

module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            startE,
  input  logic [2:0]      mdOpE,
  input  logic [XLEN-1:0] r1E,
  input  logic [XLEN-1:0] r2E,
  input  logic            flushE,
  output logic            stallE,
  output logic            busyE,
  output logic            doneE,
  output logic [XLEN-1:0] mdResultE
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        negQ_q, negQ_d;
  logic [31:0] result_q, result_d;
`ifdef MULDIV_DIV_EN
  logic        negR_q, negR_d;
  logic [32:0] divTrial;
  logic        divGe;
  logic [31:0] divRem;
  logic [63:0] divNext;
  logic [31:0] quotFix, remFix;
`endif

  logic        accept;
  logic        aSgn, bSgn, aNeg, bNeg;
  logic [31:0] aMag, bMag;
  logic [32:0] mulSum;
  logic [63:0] mulNext, prodFix;
  logic [31:0] finalRes;

  assign accept = (state_q == IDLE) & startE & ~flushE;

  // Operand signedness from funct3, then magnitudes for the unsigned datapath
  always_comb begin
    if (mdOpE[2]) begin
      aSgn = ~mdOpE[0];
      bSgn = ~mdOpE[0];
    end else begin
      aSgn = (mdOpE[1:0] != 2'b11);
      bSgn = ~mdOpE[1];
    end
    aNeg = aSgn & r1E[31];
    bNeg = bSgn & r2E[31];
    aMag = aNeg ? (32'd0 - r1E) : r1E;
    bMag = bNeg ? (32'd0 - r2E) : r2E;
  end

  // One shift-add step: acc = {partial high, remaining multiplier bits}
  always_comb begin
    mulSum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mulNext = {mulSum, acc_q[31:1]};
  end

`ifdef MULDIV_DIV_EN
  // One restoring step: acc = {partial remainder, dividend/quotient bits}
  always_comb begin
    divTrial = {acc_q[63:32], acc_q[31]};
    divGe    = (divTrial >= {1'b0, opnd_q});
    divRem   = divTrial[31:0] - opnd_q;
    divNext  = divGe ? {divRem, acc_q[30:0], 1'b1}
                     : {divTrial[31:0], acc_q[30:0], 1'b0};
  end
`endif

  // Sign correction and result selection from the finished accumulator
  always_comb begin
    prodFix  = negQ_q ? (64'd0 - acc_q) : acc_q;
    finalRes = (op_q[1:0] == 2'b00) ? prodFix[31:0] : prodFix[63:32];
`ifdef MULDIV_DIV_EN
    quotFix  = negQ_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    remFix   = negR_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    if (op_q[2]) finalRes = op_q[1] ? remFix : quotFix;
`else
    if (op_q[2]) finalRes = 32'd0;
`endif
  end

  // Next-state logic: accept in IDLE, iterate in RUN, commit in FIN
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    negQ_d   = negQ_q;
    result_d = result_q;
`ifdef MULDIV_DIV_EN
    negR_d   = negR_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          cnt_d   = 5'd0;
          op_d    = mdOpE;
          opnd_d  = aMag;
          acc_d   = {32'd0, bMag};
          negQ_d  = aNeg ^ bNeg;
          if (mdOpE[2]) begin
`ifdef MULDIV_DIV_EN
            // A zero divisor runs unsigned on the raw dividend so the
            // natural result is all-ones quotient and remainder = rs1.
            if (r2E == 32'd0) begin
              opnd_d = 32'd0;
              acc_d  = {32'd0, r1E};
              negQ_d = 1'b0;
              negR_d = 1'b0;
            end else begin
              opnd_d = bMag;
              acc_d  = {32'd0, aMag};
              negR_d = aNeg;
            end
`else
            state_d = FIN;
`endif
          end
        end
      end
      RUN: begin
        if (flushE) begin
          state_d = IDLE;
        end else begin
          acc_d = mulNext;
`ifdef MULDIV_DIV_EN
          if (op_q[2]) acc_d = divNext;
`endif
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
        if (!flushE) result_d = finalRes;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      op_q     <= 3'd0;
      acc_q    <= 64'd0;
      opnd_q   <= 32'd0;
      negQ_q   <= 1'b0;
      result_q <= 32'd0;
`ifdef MULDIV_DIV_EN
      negR_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      negQ_q   <= negQ_d;
      result_q <= result_d;
`ifdef MULDIV_DIV_EN
      negR_q   <= negR_d;
`endif
    end
  end

  assign stallE    = accept | (state_q == RUN);
  assign busyE     = (state_q != IDLE);
  assign doneE     = (state_q == FIN) & ~flushE;
  assign mdResultE = doneE ? finalRes : result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Testbench for muldiv_seq. It applies directed vectors from a table, then
// random ops checked against an arithmetic reference model. Hand-written
// sequences cover flush, reset, busy-start and back-to-back corner cases.
// Expectations follow MULDIV_DIV_EN, the same macro the design uses.
`timescale 1ns/1ps

module tb_muldiv_seq;

`ifdef MULDIV_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        startE;
  logic [2:0]  mdOpE;
  logic [31:0] r1E, r2E;
  logic        flushE;
  logic        stallE, busyE, doneE;
  logic [31:0] mdResultE;

  int checks = 0;
  int fails  = 0;
  logic [31:0] lastRes = 32'd0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .startE(startE), .mdOpE(mdOpE), .r1E(r1E),
    .r2E(r2E), .flushE(flushE), .stallE(stallE), .busyE(busyE),
    .doneE(doneE), .mdResultE(mdResultE)
  );

  // Free-running clock
  always #5 clk = ~clk;

  function automatic logic [31:0] refModel(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] ea, eb, p;
    longint      sa, sb, q, r;
    logic [63:0] qv, rv;
    if (!op[2]) begin
      ea = (op != 3'b011) ? {{32{a[31]}}, a} : {32'd0, a};
      eb = (op[1] == 1'b0) ? {{32{b[31]}}, b} : {32'd0, b};
      p  = ea * eb;
      return (op == 3'b000) ? p[31:0] : p[63:32];
    end
    if (!DivEn) return 32'd0;
    if (b == 32'd0) return op[1] ? a : 32'hFFFFFFFF;
    if (!op[0]) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = sa / sb;
      r  = sa % sb;
      qv = q;
      rv = r;
      return op[1] ? rv[31:0] : qv[31:0];
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  function automatic int expLat(input logic [2:0] op);
    return (op[2] && !DivEn) ? 1 : 33;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one op, scramble the inputs after acceptance, wait for doneE
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, output logic [31:0] res,
                               output int lat, output int stalls,
                               output bit got);
    @(negedge clk);
    startE = 1'b1; mdOpE = op; r1E = a; r2E = b;
    lat = 0; stalls = 0; got = 1'b0; res = 'x;
    #1;
    if (stallE) stalls++;
    @(posedge clk);
    #1;
    startE = 1'b0; mdOpE = 3'($urandom); r1E = $urandom; r2E = $urandom;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      lat++;
      if (stallE) stalls++;
      if (doneE) begin
        res = mdResultE;
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic runAndCheck(input string name, input logic [2:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp);
    logic [31:0] res;
    int lat, stalls;
    bit got;
    applyStimulus(op, a, b, res, lat, stalls, got);
    checkOutput({name, ".done"}, 32'(got), 32'd1);
    checkOutput({name, ".res"}, res, exp);
    checkOutput({name, ".lat"}, lat, expLat(op));
    checkOutput({name, ".stall"}, stalls, expLat(op));
    @(negedge clk);
    checkOutput({name, ".pulse"}, 32'(doneE), 32'd0);
    checkOutput({name, ".idle"}, 32'(busyE), 32'd0);
    checkOutput({name, ".hold"}, mdResultE, exp);
    lastRes = exp;
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b, res;
    int lat;
    bit got, sawDone;

    rst = 1'b1; startE = 1'b0; mdOpE = 3'd0; r1E = 32'd0; r2E = 32'd0;
    flushE = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset.stall", 32'(stallE), 32'd0);
    checkOutput("reset.busy", 32'(busyE), 32'd0);
    checkOutput("reset.done", 32'(doneE), 32'd0);
    checkOutput("reset.res", mdResultE, 32'd0);
    rst = 1'b0;

    vecs.push_back('{"mul7xm6",   3'b000, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFD6});
    vecs.push_back('{"mulhuMax",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE});
    vecs.push_back('{"mulhMax",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000});
    vecs.push_back('{"mulhsuM1",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF});
    vecs.push_back('{"mulLow0",   3'b000, 32'h00010000, 32'h00010000, 32'h00000000});
    vecs.push_back('{"mulhu1",    3'b011, 32'h00010000, 32'h00010000, 32'h00000001});
    vecs.push_back('{"divM7by2",  3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD});
    vecs.push_back('{"remM7by2",  3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF});
    vecs.push_back('{"divu5by0",  3'b101, 32'd5,        32'd0,        32'hFFFFFFFF});
    vecs.push_back('{"rem5by0",   3'b110, 32'd5,        32'd0,        32'd5});
    vecs.push_back('{"divM7by0",  3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF});
    vecs.push_back('{"remM7by0",  3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9});
    vecs.push_back('{"divOvf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000});
    vecs.push_back('{"remOvf",    3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000});
    vecs.push_back('{"rem7byM2",  3'b110, 32'd7,        32'hFFFFFFFE, 32'd1});
    vecs.push_back('{"divu100by7",3'b101, 32'd100,      32'd7,        32'd14});
    vecs.push_back('{"remu100by7",3'b111, 32'd100,      32'd7,        32'd2});
    vecs.push_back('{"divu9by3",  3'b101, 32'd9,        32'd3,        32'd3});

    foreach (vecs[i]) begin
      runAndCheck(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                  (vecs[i].op[2] && !DivEn) ? 32'd0 : vecs[i].exp);
    end

    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pickOperand();
      b  = pickOperand();
      runAndCheck("rand", op, a, b, refModel(op, a, b));
    end

    // Flush in RUN at cycle 10: no doneE, result untouched, restart works
    @(negedge clk);
    startE = 1'b1; mdOpE = 3'b000; r1E = 32'd1234; r2E = 32'd5678;
    @(posedge clk);
    #1 startE = 1'b0;
    repeat (10) @(negedge clk);
    flushE = 1'b1;
    #1 checkOutput("flushRun.done", 32'(doneE), 32'd0);
    @(posedge clk);
    #1 flushE = 1'b0;
    @(negedge clk);
    checkOutput("flushRun.busy", 32'(busyE), 32'd0);
    checkOutput("flushRun.res", mdResultE, lastRes);
    sawDone = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (doneE) sawDone = 1'b1;
    end
    checkOutput("flushRun.noDone", 32'(sawDone), 32'd0);
    runAndCheck("afterFlush", 3'b000, 32'd1234, 32'd5678, 32'd7006652);

    // Flush during FIN: doneE dropped and the held result stays the old one
    @(negedge clk);
    startE = 1'b1; mdOpE = 3'b011; r1E = 32'hFFFFFFFF; r2E = 32'hFFFFFFFF;
    @(posedge clk);
    #1 startE = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (doneE) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("flushFin.reach", 32'(got), 32'd1);
    flushE = 1'b1;
    #1;
    checkOutput("flushFin.done", 32'(doneE), 32'd0);
    checkOutput("flushFin.res", mdResultE, lastRes);
    @(posedge clk);
    #1 flushE = 1'b0;
    checkOutput("flushFin.busy", 32'(busyE), 32'd0);
    checkOutput("flushFin.hold", mdResultE, lastRes);

    // startE held high: ignored while busy, taken right after FIN
    @(negedge clk);
    startE = 1'b1; mdOpE = 3'b000; r1E = 32'd3; r2E = 32'd5;
    @(posedge clk);
    lat = 0; got = 1'b0; res = 'x;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      lat++;
      if (doneE) begin
        res = mdResultE;
        got = 1'b1;
        break;
      end
      r1E = $urandom; r2E = $urandom; mdOpE = 3'($urandom_range(1, 3));
    end
    checkOutput("busyStart.done", 32'(got), 32'd1);
    checkOutput("busyStart.lat", lat, 32'd33);
    checkOutput("busyStart.res", res, 32'd15);
    lastRes = 32'd15;
    @(negedge clk);
    checkOutput("b2b.idleStall", 32'(stallE), 32'd1);
    @(negedge clk);
    checkOutput("b2b.accepted", 32'(busyE), 32'd1);
    flushE = 1'b1;
    @(negedge clk);
    checkOutput("flushStart.stall", 32'(stallE), 32'd0);
    @(negedge clk);
    checkOutput("flushStart.busy", 32'(busyE), 32'd0);
    flushE = 1'b0; startE = 1'b0;

    // Asynchronous reset mid-RUN clears everything and abandons the op
    runAndCheck("preReset", 3'b000, 32'd6, 32'd7, 32'd42);
    @(negedge clk);
    startE = 1'b1; mdOpE = 3'b000; r1E = 32'd9; r2E = 32'd9;
    @(posedge clk);
    #1 startE = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncRst.stall", 32'(stallE), 32'd0);
    checkOutput("asyncRst.busy", 32'(busyE), 32'd0);
    checkOutput("asyncRst.done", 32'(doneE), 32'd0);
    checkOutput("asyncRst.res", mdResultE, 32'd0);
    startE = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rstStart.busy", 32'(busyE), 32'd0);
    rst = 1'b0; startE = 1'b0;
    sawDone = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (doneE) sawDone = 1'b1;
    end
    checkOutput("postRst.noDone", 32'(sawDone), 32'd0);
    checkOutput("postRst.res", mdResultE, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 startE  input  1  execute stage holds an M-extension op this cycle.
REQ-005 mdOpE  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 r1E  input  32  operand A (rs1).
REQ-007 r2E  input  32  operand B (rs2).
REQ-008 flushE  input  1  branch/trap flush of the execute stage.
REQ-009 stallE  output  1  freeze the IF/ID/EX pipeline registers.
REQ-010 busyE  output  1  FSM is not IDLE.
REQ-011 doneE  output  1  one-cycle pulse; mdResultE is valid.
REQ-012 mdResultE  output  32  operation result; held until the next acceptance.

Function
REQ-013 FSM states: IDLE, RUN, FIN.
- IDLE->RUN when startE=1 and flushE=0: operands and mdOpE latched, iteration counter=0.
- RUN->FIN after 32 iterations (counter 31).
- FIN->IDLE unconditionally.
REQ-014 Latency: doneE is high in the FIN cycle, exactly 33 cycles after the accepting edge, for exactly one cycle.
REQ-015 stallE = (IDLE & startE & ~flushE) | RUN; stallE is low in FIN so the pipeline advances and captures mdResultE.
REQ-016 Multiply: radix-2 shift-add on operand magnitudes over a 64-bit product.
- Signedness: MUL/MULH signed x signed; MULHSU signed x unsigned; MULHU unsigned x unsigned.
- Product negated in FIN when the operand signs differ.
- MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
REQ-017 Divide: radix-2 restoring on magnitudes, one quotient bit per RUN cycle.
- Signed sign fix: quotient negated if operand signs differ; remainder takes the dividend's sign.
REQ-018 Divide by zero: quotient 0xFFFFFFFF, remainder = r1E, with no sign correction; still takes 33 cycles.
REQ-019 Signed overflow (0x80000000 / 0xFFFFFFFF): DIV returns 0x80000000, REM returns 0; still takes 33 cycles.
REQ-020 startE while busy is ignored; latched operands are unaffected by input changes after acceptance.
REQ-021 flushE=1 in RUN or FIN: FSM returns to IDLE on the next edge, doneE is suppressed, mdResultE is unchanged.
REQ-022 flushE and startE high together in IDLE: the op is not accepted and stallE stays low.
REQ-023 Back-to-back ops: a new startE may be accepted in the cycle immediately after FIN.

Reset
REQ-024 rst=1 forces, immediately and asynchronously: state IDLE, counter 0, stallE=0, busyE=0, doneE=0, mdResultE=0, all internal accumulators 0.
REQ-025 Reset in mid-operation abandons the op; no doneE follows reset release.

Configuration
REQ-026 Macro MULDIV_DIV_EN defined: divide/remainder ops behave per REQ-017 to REQ-019.
REQ-027 Macro MULDIV_DIV_EN undefined: no divider logic is built.
- Ops 100-111 are accepted, go IDLE->FIN directly, and return mdResultE=0 with doneE one cycle after acceptance.
- stallE is high only in the accepting cycle.
- Multiply behaviour is unchanged.

Verification
REQ-028 MUL r1=7, r2=0xFFFFFFFA (-6) -> doneE at +33, mdResultE=0xFFFFFFD6; stallE high for 33 cycles.
REQ-029 MULHU r1=r2=0xFFFFFFFF -> mdResultE=0xFFFFFFFE; MULH on the same operands -> 0x00000000.
REQ-030 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000.
REQ-031 Start MUL, assert flushE at cycle 10 -> busyE=0 at cycle 11, no doneE, mdResultE unchanged; new start accepted at cycle 12.
REQ-032 Assert rst asynchronously mid-RUN -> all outputs 0 within the same cycle; no doneE after release; startE ignored while rst=1.
REQ-033 With MULDIV_DIV_EN undefined: DIVU 9/3 -> doneE one cycle after acceptance, mdResultE=0.
